// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic ARB_OWNER_INST = 1'b0;
  localparam logic ARB_OWNER_DATA = 1'b1;
  localparam int unsigned ARB_QENT_WD = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  // Response-queue entry: who owns the outstanding response and whether to drop it.
  typedef struct packed {
    logic owner;
    logic discard;
  } arb_qent_t;

endpackage

// File: rtl/arb_resp_queue.sv
// Circular FIFO of {owner,discard} entries tracking responses still owed by the bus.
module arb_resp_queue
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  arb_qent_t        push_ent,
  input  logic             pop,
  input  logic             mark_inst_discard,
  output logic [CNT_W-1:0] count,
  output arb_qent_t        head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_qent_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Head of queue is the oldest outstanding response.
  always_comb begin
    head = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; a push lands after the flush broadcast so it keeps its own flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (mark_inst_discard) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (mem[i].owner == ARB_OWNER_INST) begin
            mem[i].discard <= 1'b1;
          end
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one SRAM-like bus, in-order responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state;
  logic [STV_W-1:0] starve;
  logic             issue_owner;
  logic             issue_discard;
  logic [CNT_W-1:0] q_count;
  arb_qent_t        q_head;
  arb_qent_t        push_ent;
  logic             push_fire;
  logic             pop_fire;
  logic             can_accept;
  logic             grant_inst;
  logic             head_inst_ok;

  arb_resp_queue #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_resp_queue (
    .clk               (clk),
    .reset             (reset),
    .push              (push_fire),
    .push_ent          (push_ent),
    .pop               (pop_fire),
    .mark_inst_discard (inst_cancel),
    .count             (q_count),
    .head              (q_head)
  );

  // Grant, queue handshake and response routing; a pop frees a slot for a same-cycle accept.
  always_comb begin
    pop_fire     = bus_data_ok && (q_count != '0);
    can_accept   = (state == ST_IDLE) && ((q_count < CNT_W'(OUTSTANDING)) || pop_fire);
    grant_inst   = inst_req && (!data_req || (starve == STV_W'(STARVE_LIMIT)));
    inst_addr_ok = can_accept && grant_inst;
    data_addr_ok = can_accept && data_req && !grant_inst;

    push_fire        = (state == ST_ISSUE) && bus_addr_ok;
    push_ent.owner   = issue_owner;
    push_ent.discard = issue_discard || (inst_cancel && (issue_owner == ARB_OWNER_INST));

    head_inst_ok = !q_head.discard && !inst_cancel;
    data_data_ok = pop_fire && (q_head.owner == ARB_OWNER_DATA);
    inst_data_ok = pop_fire && (q_head.owner == ARB_OWNER_INST) && head_inst_ok;
    data_rdata   = data_data_ok ? bus_rdata : 32'h0;
    inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
  end

  // IDLE/ISSUE sequencing, bus payload registers and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      starve        <= '0;
      issue_owner   <= ARB_OWNER_INST;
      issue_discard <= 1'b0;
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_size      <= 2'd0;
      bus_wstrb     <= 4'h0;
      bus_addr      <= 32'h0;
      bus_wdata     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst_addr_ok) begin
            state         <= ST_ISSUE;
            starve        <= '0;
            issue_owner   <= ARB_OWNER_INST;
            issue_discard <= 1'b0;
            bus_req       <= 1'b1;
            bus_wr        <= 1'b0;
            bus_size      <= 2'd2;
            bus_wstrb     <= 4'h0;
            bus_addr      <= inst_addr;
            bus_wdata     <= 32'h0;
          end else if (data_addr_ok) begin
            state         <= ST_ISSUE;
            issue_owner   <= ARB_OWNER_DATA;
            issue_discard <= 1'b0;
            bus_req       <= 1'b1;
            bus_wr        <= data_wr;
            bus_size      <= data_size;
            bus_wstrb     <= data_wstrb;
            bus_addr      <= data_addr;
            bus_wdata     <= data_wdata;
            if (inst_req && (starve != STV_W'(STARVE_LIMIT))) begin
              starve <= starve + STV_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (bus_addr_ok) begin
            state   <= ST_IDLE;
            bus_req <= 1'b0;
          end else if (inst_cancel && (issue_owner == ARB_OWNER_INST)) begin
            issue_discard <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (OUTSTANDING=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .OUTSTANDING  (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_cancel  (inst_cancel),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic smp();
    @(negedge clk);
  endtask

  logic [10:0] exp_d, exp_i, exp_dok, exp_iok;

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    nxt(); nxt(); smp();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_size", 32'(bus_size), 32'd0);

    // 1. Single fetch
    nxt(); reset = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000000; smp();
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    check("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    nxt(); inst_req = 1'b0; bus_addr_ok = 1'b1; smp();
    check("t1_bus_req", 32'(bus_req), 32'd1);
    check("t1_bus_addr", bus_addr, 32'h1c000000);
    check("t1_bus_size", 32'(bus_size), 32'd2);
    check("t1_bus_wr", 32'(bus_wr), 32'd0);
    nxt(); bus_addr_ok = 1'b0; smp();
    check("t1_bus_req_drop", 32'(bus_req), 32'd0);
    nxt(); bus_data_ok = 1'b1; bus_rdata = 32'h02800400; smp();
    check("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    check("t1_inst_rdata", inst_rdata, 32'h02800400);
    check("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    check("t1_data_rdata", data_rdata, 32'h0);
    nxt(); bus_data_ok = 1'b0; bus_rdata = '0; smp();
    check("t1_inst_data_ok_end", 32'(inst_data_ok), 32'd0);

    // 2. Contention with starvation forcing an inst grant after 4 data grants
    exp_d   = 11'b10001010101;
    exp_i   = 11'b00100000000;
    exp_dok = 11'b00101010100;
    exp_iok = 11'b10000000000;
    nxt();
    inst_req = 1'b1; inst_addr = 32'h1c000040;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3;
    data_addr = 32'h100; data_wdata = 32'h00001234;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5;
    for (int i = 0; i < 11; i++) begin
      smp();
      check($sformatf("t2_data_addr_ok[%0d]", i), 32'(data_addr_ok), 32'(exp_d[i]));
      check($sformatf("t2_inst_addr_ok[%0d]", i), 32'(inst_addr_ok), 32'(exp_i[i]));
      check($sformatf("t2_data_data_ok[%0d]", i), 32'(data_data_ok), 32'(exp_dok[i]));
      check($sformatf("t2_inst_data_ok[%0d]", i), 32'(inst_data_ok), 32'(exp_iok[i]));
      if (i == 1) begin
        check("t2_bus_wr", 32'(bus_wr), 32'd1);
        check("t2_bus_wstrb", 32'(bus_wstrb), 32'h3);
        check("t2_bus_addr", bus_addr, 32'h100);
      end
      if (i == 9) begin
        check("t2_inst_bus_wr", 32'(bus_wr), 32'd0);
        check("t2_inst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        check("t2_inst_bus_addr", bus_addr, 32'h1c000040);
      end
      nxt();
    end
    inst_req = 1'b0; data_req = 1'b0; smp();
    nxt(); smp();
    check("t2_drain_data_ok", 32'(data_data_ok), 32'd1);
    nxt(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; smp();

    // 3. Full queue with responses held off
    nxt();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h180; bus_addr_ok = 1'b1; smp();
    check("t3_acc0", 32'(data_addr_ok), 32'd1);
    nxt(); smp();
    nxt(); smp();
    check("t3_acc1", 32'(data_addr_ok), 32'd1);
    nxt(); smp();
    nxt(); smp();
    check("t3_full0", 32'(data_addr_ok), 32'd0);
    nxt(); smp();
    check("t3_full1", 32'(data_addr_ok), 32'd0);
    nxt(); bus_data_ok = 1'b1; bus_rdata = 32'h11; smp();
    check("t3_acc2_on_pop", 32'(data_addr_ok), 32'd1);
    check("t3_pop_data_ok", 32'(data_data_ok), 32'd1);
    nxt(); data_req = 1'b0; bus_data_ok = 1'b0; smp();
    nxt(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h22; smp();
    check("t3_resp2", data_rdata, 32'h22);
    nxt(); bus_rdata = 32'h33; smp();
    check("t3_resp3", data_rdata, 32'h33);
    nxt(); bus_rdata = 32'h44; smp();
    check("t3_empty_data_ok", 32'(data_data_ok), 32'd0);
    check("t3_empty_inst_ok", 32'(inst_data_ok), 32'd0);
    nxt(); bus_data_ok = 1'b0; bus_rdata = '0; smp();

    // 4. Flush of two outstanding fetches, then a load
    nxt(); inst_req = 1'b1; inst_addr = 32'h1c000100; bus_addr_ok = 1'b1; smp();
    nxt(); smp();
    nxt(); smp();
    check("t4_fetch2_acc", 32'(inst_addr_ok), 32'd1);
    nxt(); inst_req = 1'b0; smp();
    nxt(); inst_cancel = 1'b1; smp();
    nxt(); inst_cancel = 1'b0; data_req = 1'b1; data_addr = 32'h200;
    bus_data_ok = 1'b1; bus_rdata = 32'hdead0001; smp();
    check("t4_drop1_inst_ok", 32'(inst_data_ok), 32'd0);
    check("t4_load_acc", 32'(data_addr_ok), 32'd1);
    nxt(); data_req = 1'b0; bus_rdata = 32'hdead0002; smp();
    check("t4_drop2_inst_ok", 32'(inst_data_ok), 32'd0);
    check("t4_drop2_data_ok", 32'(data_data_ok), 32'd0);
    nxt(); bus_addr_ok = 1'b0; bus_rdata = 32'h0000cafe; smp();
    check("t4_load_data_ok", 32'(data_data_ok), 32'd1);
    check("t4_load_rdata", data_rdata, 32'h0000cafe);
    nxt(); bus_data_ok = 1'b0; bus_rdata = '0; smp();

    // 5. Mixed order: inst then data
    nxt(); inst_req = 1'b1; inst_addr = 32'h1c000200; bus_addr_ok = 1'b1; smp();
    check("t5_inst_acc", 32'(inst_addr_ok), 32'd1);
    nxt(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h300; smp();
    check("t5_no_acc_in_issue", 32'(data_addr_ok), 32'd0);
    nxt(); smp();
    check("t5_data_acc", 32'(data_addr_ok), 32'd1);
    nxt(); data_req = 1'b0; smp();
    nxt(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA0000; smp();
    check("t5_inst_ok", 32'(inst_data_ok), 32'd1);
    check("t5_inst_rdata", inst_rdata, 32'hAAAA0000);
    check("t5_data_ok_0", 32'(data_data_ok), 32'd0);
    nxt(); bus_rdata = 32'h0000BBBB; smp();
    check("t5_data_ok", 32'(data_data_ok), 32'd1);
    check("t5_data_rdata", data_rdata, 32'h0000BBBB);
    check("t5_inst_ok_1", 32'(inst_data_ok), 32'd0);
    nxt(); bus_data_ok = 1'b0; bus_rdata = '0; smp();

    // 6. Reset while in ISSUE with one queued entry
    nxt(); inst_req = 1'b1; inst_addr = 32'h1c000300; bus_addr_ok = 1'b1; smp();
    nxt(); smp();
    nxt(); smp();
    nxt(); inst_req = 1'b0; bus_addr_ok = 1'b0; smp();
    check("t6_in_issue", 32'(bus_req), 32'd1);
    reset = 1'b1;
    nxt(); reset = 1'b0; smp();
    check("t6_bus_req_after_rst", 32'(bus_req), 32'd0);
    nxt(); inst_req = 1'b1; inst_addr = 32'h1c000400; bus_data_ok = 1'b1; bus_rdata = 32'h77; smp();
    check("t6_fresh_acc", 32'(inst_addr_ok), 32'd1);
    check("t6_queue_empty", 32'(inst_data_ok), 32'd0);
    nxt(); inst_req = 1'b0; bus_data_ok = 1'b0; bus_addr_ok = 1'b1; smp();
    check("t6_bus_req", 32'(bus_req), 32'd1);
    check("t6_bus_addr", bus_addr, 32'h1c000400);
    nxt(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h88; smp();
    check("t6_resp", inst_rdata, 32'h88);
    nxt(); bus_data_ok = 1'b0; smp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
